// File: rtl/counter_select_mux.sv
// ---------------------------------------------------------------------------
// counter_select_mux
//
// Purpose:
//   This block is a WIDTH-bit enable/clear binary counter. It can count up or
//   down, and it can either wrap or saturate at its end values. It also
//   provides a priority-select output:
//     - z picks one of the c data lines, using the lowest set bit of the
//       current count.
//     - z_q is a registered copy of z.
//     - wrapped is a sticky flag that records any wrap or saturation event.
//
// Parameters:
//   WIDTH     counter width in bits (2..64)
//   TC_BITS   number of counter MSBs ANDed to form w (1..WIDTH)
//   SATURATE  0 = wrap at the end values, 1 = hold at the end values
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset (highest priority)
//   clear       in   synchronous clear of count and wrapped
//   x           in   count enable; also qualifies z
//   dir         in   count direction, 0 = up, 1 = down
//   load        in   parallel load strobe (optional, see below)
//   load_value  in   value loaded by load (optional, see below)
//   c           in   WIDTH+1 select data lines; c[0] is always selected
//   count       out  registered counter value
//   w           out  terminal flag, AND of the top TC_BITS count bits
//   z           out  combinational priority-select output
//   z_q         out  z registered, one cycle latency
//   wrapped     out  sticky wrap/saturation flag
//
// Configuration:
//   Define COUNTER_SELECT_MUX_LOAD_EN to add the load / load_value ports.
//   Load sits below clear and above x in priority, and it leaves wrapped
//   untouched.
// ---------------------------------------------------------------------------
module counter_select_mux #(
    parameter int WIDTH    = 32,
    parameter int TC_BITS  = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             x,
    input  logic             dir,
`ifdef COUNTER_SELECT_MUX_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
`endif
    input  logic [WIDTH:0]   c,
    output logic [WIDTH-1:0] count,
    output logic             w,
    output logic             z,
    output logic             z_q,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Reject parameter combinations that would give meaningless part selects.
    generate
        if (WIDTH < 2 || WIDTH > 64) begin : gWidthCheck
            $error("counter_select_mux: WIDTH must be in 2..64");
        end
        if (TC_BITS < 1 || TC_BITS > WIDTH) begin : gTcCheck
            $error("counter_select_mux: TC_BITS must be in 1..WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrapped_q;
    logic             wrapped_d;
    logic             zReg_q;

    logic             atMax;
    logic             atMin;
    logic [WIDTH-1:0] lowestOneHot;
    logic             sel;

    assign atMax = &count_q;
    assign atMin = ~|count_q;

    // Next-state logic for count and wrapped.
    // Priority: clear, then the optional load, then enable; otherwise hold.
    // Any step past an end value sets wrapped. In saturate mode that step
    // leaves the count where it is.
    always_comb begin
        count_d   = count_q;
        wrapped_d = wrapped_q;
        if (clear) begin
            count_d   = '0;
            wrapped_d = 1'b0;
        end
`ifdef COUNTER_SELECT_MUX_LOAD_EN
        else if (load) begin
            count_d = load_value;
        end
`endif
        else if (x) begin
            if (!dir) begin
                if (atMax) begin
                    wrapped_d = 1'b1;
                    count_d   = SATURATE ? count_q : '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (atMin) begin
                    wrapped_d = 1'b1;
                    count_d   = SATURATE ? count_q : '1;
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
    end

    // State registers.
    // z_q samples z on every non-reset edge, including clear and hold
    // cycles, so it always shows last cycle's select result.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            wrapped_q <= 1'b0;
            zReg_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            zReg_q    <= z;
        end
    end

    // count & -count isolates the lowest set bit as a one-hot vector.
    // It is all zeros when count is zero, which gives sel = 0 in that case
    // with no special handling.
    assign lowestOneHot = count_q & (~count_q + ONE);
    assign sel          = |(lowestOneHot & c[WIDTH:1]);
    assign z            = x & (c[0] | sel);

    assign w       = &count_q[WIDTH-1 -: TC_BITS];
    assign count   = count_q;
    assign z_q     = zReg_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_counter_select_mux.sv
// ---------------------------------------------------------------------------
// tb_counter_select_mux
//
// Directed bench with three counter_select_mux instances:
//   - A default 32-bit wrapping instance.
//   - Two 4-bit instances (TC_BITS=2). One wraps and one saturates, so the
//     up-direction end value can be reached in a few cycles.
// Every expected value below is worked out by hand from the counter's
// behaviour.
// ---------------------------------------------------------------------------
module tb_counter_select_mux;

    logic        clock;
    logic        reset;
    logic        clear;
    logic        x;
    logic        dir;
    logic [32:0] c;
    logic [31:0] count;
    logic        w;
    logic        z;
    logic        zQ;
    logic        wrapped;

    logic        xSmall;
    logic        dirSmall;
    logic [4:0]  cSmall;
    logic [3:0]  smallCount;
    logic        smallW;
    logic        smallZ;
    logic        smallZQ;
    logic        smallWrapped;
    logic [3:0]  satCount;
    logic        satW;
    logic        satZ;
    logic        satZQ;
    logic        satWrapped;

`ifdef COUNTER_SELECT_MUX_LOAD_EN
    logic        load;
    logic [31:0] loadValue;
`endif

    int checks   = 0;
    int failures = 0;

    counter_select_mux #(.WIDTH(32), .TC_BITS(4), .SATURATE(1'b0)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .x          (x),
        .dir        (dir),
`ifdef COUNTER_SELECT_MUX_LOAD_EN
        .load       (load),
        .load_value (loadValue),
`endif
        .c          (c),
        .count      (count),
        .w          (w),
        .z          (z),
        .z_q        (zQ),
        .wrapped    (wrapped)
    );

    counter_select_mux #(.WIDTH(4), .TC_BITS(2), .SATURATE(1'b0)) u_small (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .x          (xSmall),
        .dir        (dirSmall),
`ifdef COUNTER_SELECT_MUX_LOAD_EN
        .load       (1'b0),
        .load_value (4'h0),
`endif
        .c          (cSmall),
        .count      (smallCount),
        .w          (smallW),
        .z          (smallZ),
        .z_q        (smallZQ),
        .wrapped    (smallWrapped)
    );

    counter_select_mux #(.WIDTH(4), .TC_BITS(2), .SATURATE(1'b1)) u_sat (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .x          (xSmall),
        .dir        (dirSmall),
`ifdef COUNTER_SELECT_MUX_LOAD_EN
        .load       (1'b0),
        .load_value (4'h0),
`endif
        .c          (cSmall),
        .count      (satCount),
        .w          (satW),
        .z          (satZ),
        .z_q        (satZQ),
        .wrapped    (satWrapped)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge, then settle past it so that inputs and samples stay
    // clear of the active edge.
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    // One comparison: count it, and on a mismatch count the failure and
    // report it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Directed sequence; each step notes the expected state it sets up.
    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        x        = 1'b0;
        dir      = 1'b0;
        c        = '0;
        xSmall   = 1'b0;
        dirSmall = 1'b0;
        cSmall   = '0;
`ifdef COUNTER_SELECT_MUX_LOAD_EN
        load      = 1'b0;
        loadValue = '0;
`endif
        #2;
        applyStimulus();
        applyStimulus();
        checkOutput("reset_count",   64'(count),   64'h0);
        checkOutput("reset_zq",      64'(zQ),      64'h0);
        checkOutput("reset_wrapped", 64'(wrapped), 64'h0);
        checkOutput("reset_w",       64'(w),       64'h0);
        checkOutput("reset_z",       64'(z),       64'h0);
        checkOutput("reset_small",   64'(smallCount), 64'h0);

        // Five up counts from zero.
        reset = 1'b0;
        x     = 1'b1;
        dir   = 1'b0;
        repeat (5) applyStimulus();
        checkOutput("up5_count",   64'(count),   64'h5);
        checkOutput("up5_w",       64'(w),       64'h0);
        checkOutput("up5_wrapped", 64'(wrapped), 64'h0);
        checkOutput("up5_z_c0",    64'(z),       64'h0);

        // count=5: lowest set bit is 0, so c[1] is selected.
        c = 33'h2;
        #1;
        checkOutput("z_bit0_c1", 64'(z), 64'h1);
        c = 33'h4;
        #1;
        checkOutput("z_bit0_c2", 64'(z), 64'h0);
        x = 1'b0;
        c = 33'h1_FFFF_FFFF;
        #1;
        checkOutput("z_x_low", 64'(z), 64'h0);

        // Clear wins over enable.
        clear = 1'b1;
        x     = 1'b1;
        c     = '0;
        applyStimulus();
        checkOutput("clear_count", 64'(count), 64'h0);

        // Count to 0x18: the lowest set bit is 3, so c[4] is selected.
        clear = 1'b0;
        repeat (24) applyStimulus();
        checkOutput("up24_count", 64'(count), 64'h18);
        c = 33'h10;
        #1;
        checkOutput("z_sel_c4", 64'(z), 64'h1);
        c = 33'h0;
        #1;
        checkOutput("z_c4_low", 64'(z), 64'h0);
        c = 33'h10;
        applyStimulus();
        checkOutput("zq_latency", 64'(zQ),    64'h1);
        checkOutput("z_0x19",     64'(z),     64'h0);
        checkOutput("count_0x19", 64'(count), 64'h19);

        // A hold cycle still updates z_q.
        x = 1'b0;
        c = '0;
        applyStimulus();
        checkOutput("hold_count", 64'(count), 64'h19);
        checkOutput("hold_zq",    64'(zQ),    64'h0);

        // Down count from zero wraps to all-ones.
        clear = 1'b1;
        applyStimulus();
        clear = 1'b0;
        dir   = 1'b1;
        x     = 1'b1;
        applyStimulus();
        checkOutput("down_wrap_count",   64'(count),   64'hFFFF_FFFF);
        checkOutput("down_wrap_wrapped", 64'(wrapped), 64'h1);
        checkOutput("down_wrap_w",       64'(w),       64'h1);
        x = 1'b0;
        applyStimulus();
        checkOutput("sticky_count",   64'(count),   64'hFFFF_FFFF);
        checkOutput("sticky_wrapped", 64'(wrapped), 64'h1);

        // Clear with x=1 and dir=1: a down step would give FFFFFFFE.
        // z is 1 through c[0], and z_q captures it on the clear edge.
        clear = 1'b1;
        x     = 1'b1;
        c     = 33'h1;
        applyStimulus();
        checkOutput("clear_x_count",   64'(count),   64'h0);
        checkOutput("clear_x_wrapped", 64'(wrapped), 64'h0);
        checkOutput("clear_x_zq",      64'(zQ),      64'h1);

        // Reset in the middle of a count.
        clear = 1'b0;
        dir   = 1'b0;
        repeat (3) applyStimulus();
        checkOutput("mid_count", 64'(count), 64'h3);
        checkOutput("mid_zq",    64'(zQ),    64'h1);
        reset = 1'b1;
        applyStimulus();
        checkOutput("mid_reset_count", 64'(count), 64'h0);
        checkOutput("mid_reset_zq",    64'(zQ),    64'h0);
        reset = 1'b0;
        x     = 1'b0;
        c     = '0;

        // 4-bit instances: count up to all-ones, then one more step.
        xSmall   = 1'b1;
        dirSmall = 1'b0;
        repeat (15) applyStimulus();
        checkOutput("small_15_count",   64'(smallCount),   64'hF);
        checkOutput("small_15_w",       64'(smallW),       64'h1);
        checkOutput("small_15_wrapped", 64'(smallWrapped), 64'h0);
        checkOutput("sat_15_wrapped",   64'(satWrapped),   64'h0);
        applyStimulus();
        checkOutput("small_wrap_count",   64'(smallCount),   64'h0);
        checkOutput("small_wrap_wrapped", 64'(smallWrapped), 64'h1);
        checkOutput("small_wrap_w",       64'(smallW),       64'h0);
        checkOutput("sat_hold_count",     64'(satCount),     64'hF);
        checkOutput("sat_hold_wrapped",   64'(satWrapped),   64'h1);
        checkOutput("sat_hold_w",         64'(satW),         64'h1);
        applyStimulus();
        checkOutput("small_after_wrap", 64'(smallCount), 64'h1);
        checkOutput("sat_still_max",    64'(satCount),   64'hF);

        // Down direction at zero: wrap versus saturate.
        reset = 1'b1;
        applyStimulus();
        reset    = 1'b0;
        dirSmall = 1'b1;
        applyStimulus();
        checkOutput("small_down_count",   64'(smallCount), 64'hF);
        checkOutput("sat_down_count",     64'(satCount),   64'h0);
        checkOutput("sat_down_wrapped",   64'(satWrapped), 64'h1);
        xSmall = 1'b0;

`ifdef COUNTER_SELECT_MUX_LOAD_EN
        // Load beats enable and keeps wrapped. 0xF000 has its lowest set
        // bit at 12, so c[13] is selected.
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        dir   = 1'b1;
        x     = 1'b1;
        applyStimulus();
        load      = 1'b1;
        loadValue = 32'h0000_F000;
        applyStimulus();
        checkOutput("load_count",   64'(count),   64'hF000);
        checkOutput("load_wrapped", 64'(wrapped), 64'h1);
        load = 1'b0;
        c    = 33'h2000;
        #1;
        checkOutput("load_z_c13", 64'(z), 64'h1);
        x = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_select_mux.md
Name: counter_select_mux

Overview:
- Parametrised successor to the team's fixed 32-stage enable/clear counter with priority select output.
- WIDTH-bit binary counter, advanced by enable `x` and cleared synchronously by `clear`.
- Terminal flag `w` asserts when the top TC_BITS counter bits are all ones.
- Priority-select output `z` gates one of the `c` data lines, chosen by the lowest set counter bit.
- New over the predecessor: up/down mode, wrap-or-saturate mode, a registered copy of `z`, and a sticky wrap event flag.
- Sits in the control path beside other counter-style blocks.

Parameters:
- WIDTH, 32, counter width in bits; legal range 2..64.
- TC_BITS, 4, number of MSBs ANDed to form `w`; must satisfy 1 <= TC_BITS <= WIDTH.
- SATURATE, 0, selects overflow behaviour: 0 = count wraps; 1 = count holds at the end value.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- clear  in  1  synchronous clear of the count; lower priority than `reset`.
- x  in  1  count enable; also qualifies `z`.
- dir  in  1  count direction: 0 = up, 1 = down.
- c  in  WIDTH+1  select data lines; `c[0]` is the always-selected line.
- count  out  WIDTH  current counter value (registered).
- w  out  1  terminal flag: AND of `count[WIDTH-1 : WIDTH-TC_BITS]` (combinational from `count`).
- z  out  1  combinational priority-select output.
- z_q  out  1  `z` registered; 1-cycle latency.
- wrapped  out  1  sticky flag: set on a wrap or saturation event, cleared by `reset` or `clear`.

Behaviour:
- Reset values: `reset` high at a clock edge forces `count` = 0, `z_q` = 0, `wrapped` = 0. `w` and `z` follow their equations from `count` = 0.
- Update priority at each clock edge:
  1. `reset`.
  2. `clear`: `count` = 0, `wrapped` = 0; `z_q` still captures `z`.
  3. `x` = 1: count up or down per `dir`.
  4. Otherwise hold.
- Up count: `count` = `count` + 1 modulo 2^WIDTH.
  - At all-ones with SATURATE=0: next value 0 and `wrapped` sets.
  - At all-ones with SATURATE=1: holds all-ones and `wrapped` sets.
- Down count: `count` = `count` - 1.
  - At 0 with SATURATE=0: next value all-ones and `wrapped` sets.
  - At 0 with SATURATE=1: holds 0 and `wrapped` sets.
- `wrapped` stays set until `reset` or `clear`.
- Changing `dir` takes effect on the same edge; there is no pipeline.
- `z` = `x` AND (`c[0]` OR `sel`), where:
  - `sel` = `c[k+1]` and k is the index of the lowest set bit of `count`;
  - `sel` = 0 when `count` = 0.
- `z` is purely combinational from `x`, `c` and `count`; it uses the pre-edge `count`.
- `z_q` captures `z` every non-reset edge, including hold and clear cycles.
- With `x` = 0, `z` = 0 regardless of `c`.
- `w` is independent of `x` and `dir`.
- `clear` and `x` both high: clear wins and the count does not advance.
- `reset` asserted mid-count: the next edge forces the reset values; there is no partial state.
- No internal state outside `count`, `z_q`, `wrapped`, plus the optional load path.

Optional Feature:
- Macro: COUNTER_SELECT_MUX_LOAD_EN.
- When defined, adds two ports:
  - `load`  in  1  parallel load strobe.
  - `load_value`  in  WIDTH  value to load.
- Load priority sits between `clear` and `x`: `load` = 1 sets `count` = `load_value` and leaves `wrapped` unchanged.
- When undefined, neither port exists and the priority order is exactly as listed in Behaviour.

Test Plan:
- Reset, then `x` = 1, `dir` = 0 for 5 cycles (WIDTH=32) → `count` = 5, `w` = 0, `wrapped` = 0.
- From `count` = 0xFFFFFFFF with `x` = 1 (SATURATE=0) → next `count` = 0, `wrapped` = 1. `w` = 1 in the cycle before the wrap and 0 after it.
- Same start with SATURATE=1 → `count` stays 0xFFFFFFFF, `wrapped` = 1.
- `count` = 0x00000018, `x` = 1, `c` = 1 << 4 only → `z` = 1 (lowest set bit is 3, so `c[4]` is selected). `z_q` = 1 one cycle later. With `c[4]` = 0 → `z` = 0.
- `count` = 0, `x` = 1, `dir` = 1 → `count` = 0xFFFFFFFF, `wrapped` = 1. Then `clear` and `x` both high → `count` = 0, `wrapped` = 0.
- Macro defined: `load` = 1 with `load_value` = 0x0000F000 while `x` = 1 → `count` = 0x0000F000. Then `c` = 1 << 13, `x` = 1 → `z` = 1.
